// File: rtl/mct_timer.sv
// mct_timer: memory-cycle-time (MCT) sequencer.
// Produces the phase counter, one-hot time pulses and RT/WT/CT strobes. It also
// provides monitor stop / single step, standby hold and GOJAM restart sequencing.
// Every halt and restart transition happens on the clock that ends an MCT, so
// downstream logic always sees whole memory cycles.

module mct_timer #(
   parameter int NUM_TP     = 12,
   parameter int CLK_PER_TP = 4,
   parameter int GOJAM_MCT  = 2,
   localparam int TPW = $clog2(NUM_TP),
   localparam int PW  = $clog2(CLK_PER_TP),
   localparam int CW  = $clog2(GOJAM_MCT + 1)
) (
   input  logic              clock,
   input  logic              rst_n,
   input  logic              sby,
   input  logic              mstp,
   input  logic              mstrtp,
   input  logic              goj_req,
   input  logic              strt_req,
   output logic [NUM_TP-1:0] tp,
   output logic [TPW-1:0]    tp_idx,
   output logic [PW-1:0]     phase,
   output logic              rt,
   output logic              wt,
   output logic              ct,
   output logic              mct_end,
   output logic              stop,
   output logic              stby,
   output logic              gojam,
   output logic              gojam_n
);

   // Decode constants, sized to the counters they are compared against.
   localparam logic [TPW-1:0] TP_LAST = TPW'(NUM_TP - 1);
   localparam logic [PW-1:0]  PH_LAST = PW'(CLK_PER_TP - 1);
   localparam logic [PW-1:0]  PH_WT   = PW'(CLK_PER_TP / 2);
   localparam logic [CW-1:0]  GJ_LOAD = CW'(GOJAM_MCT);
   localparam logic [CW-1:0]  GJ_ONE  = CW'(1);

   // Halt mode of the sequencer; only RUN lets the counters advance.
   typedef enum logic [1:0] {
      HALT_RUN  = 2'd0,
      HALT_STOP = 2'd1,
      HALT_STBY = 2'd2
   } halt_e;

   halt_e            halt_q, halt_d;
   logic             mstrtp_q;
   logic [TPW-1:0]   tp_idx_q, tp_idx_d;
   logic [PW-1:0]    phase_q, phase_d;
   logic             pending_q, pending_d;
   logic [CW-1:0]    gj_cnt_q, gj_cnt_d;
   logic             gojam_q, gojam_d;

   logic             run;
   logic             step_rise;
   logic             wake;
   logic             restart_req;

   assign step_rise   = mstrtp & ~mstrtp_q;
   assign wake        = (halt_q == HALT_STBY) & ~sby;
   assign restart_req = goj_req | strt_req;

   // Halt-mode state register and monitor-start edge detector.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the values that were present before the clock edge.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         halt_q   <= HALT_RUN;
         mstrtp_q <= 1'b0;
      end else begin
         halt_q   <= halt_d;
         mstrtp_q <= mstrtp;
      end
   end

   // Halt-mode next state: standby beats monitor stop at an MCT boundary.
   // A single step needs no separate grant flag: the mct_end closing the
   // stepped MCT re-checks mstp, so exactly one MCT runs per rising edge.
   // NOTE: every signal written here gets a default first so no latch is
   // inferred for the paths that leave it unchanged.
   always_comb begin
      halt_d = halt_q;
      unique case (halt_q)
         HALT_RUN: begin
            if (mct_end) begin
               if (sby) begin
                  halt_d = HALT_STBY;
               end else if (mstp) begin
                  halt_d = HALT_STOP;
               end
            end
         end
         HALT_STOP: begin
            if (!mstp || step_rise) begin
               halt_d = HALT_RUN;
            end
         end
         HALT_STBY: begin
            if (!sby) begin
               halt_d = HALT_RUN;
            end
         end
         default: halt_d = HALT_RUN;
      endcase
   end

   // Output decode: halt flags plus strobes gated by run (and by reset, so
   // nothing pulses while rst_n is held low).
   always_comb begin
      stop    = (halt_q == HALT_STOP);
      stby    = (halt_q == HALT_STBY);
      run     = rst_n & (halt_q == HALT_RUN);
      tp      = '0;
      rt      = 1'b0;
      wt      = 1'b0;
      ct      = 1'b0;
      mct_end = 1'b0;
      if (run) begin
         tp      = NUM_TP'(1) << tp_idx_q;
         rt      = (phase_q == '0);
         wt      = (phase_q == PH_WT);
         ct      = (phase_q == PH_LAST);
         mct_end = (phase_q == PH_LAST) && (tp_idx_q == TP_LAST);
      end
   end

   // Phase / time-pulse counters: advance while running, park at T01 phase 0
   // while halted so a resume always starts a fresh MCT.
   always_comb begin
      tp_idx_d = tp_idx_q;
      phase_d  = phase_q;
      if (!run) begin
         tp_idx_d = '0;
         phase_d  = '0;
      end else if (phase_q == PH_LAST) begin
         phase_d  = '0;
         tp_idx_d = (tp_idx_q == TP_LAST) ? '0 : tp_idx_q + TPW'(1);
      end else begin
         phase_d  = phase_q + PW'(1);
      end
   end

   // GOJAM sequencing: requests are latched at any time and act at the next
   // MCT boundary; the counter measures the assertion in whole MCTs and a
   // reload always wins over expiry. Waking from standby also restarts.
   always_comb begin
      pending_d = pending_q | restart_req;
      gj_cnt_d  = gj_cnt_q;
      gojam_d   = gojam_q;
      if (wake) begin
         gj_cnt_d = GJ_LOAD;
         gojam_d  = 1'b1;
      end else if (mct_end) begin
         // A request arriving on the boundary clock stays queued for the next MCT.
         pending_d = restart_req;
         if (pending_q) begin
            gj_cnt_d = GJ_LOAD;
            gojam_d  = 1'b1;
         end else if (gj_cnt_q != '0) begin
            gj_cnt_d = gj_cnt_q - GJ_ONE;
            if (gj_cnt_q == GJ_ONE) begin
               gojam_d = 1'b0;
            end
         end
      end
   end

   // Datapath registers: counters and restart state; gojam powers up asserted.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         tp_idx_q  <= '0;
         phase_q   <= '0;
         pending_q <= 1'b0;
         gj_cnt_q  <= GJ_LOAD;
         gojam_q   <= 1'b1;
      end else begin
         tp_idx_q  <= tp_idx_d;
         phase_q   <= phase_d;
         pending_q <= pending_d;
         gj_cnt_q  <= gj_cnt_d;
         gojam_q   <= gojam_d;
      end
   end

   assign tp_idx  = tp_idx_q;
   assign phase   = phase_q;
   assign gojam   = gojam_q;
   assign gojam_n = ~gojam_q;

endmodule

// File: tb/tb_mct_timer.sv
// Testbench for mct_timer: default instance plus a 4 x 6 / GOJAM 3 instance
// sharing one stimulus stream, each compared every clock against a model
// that tracks the position inside the MCT as a single integer.

module tb_mct_timer;

   localparam int NTP [2] = '{12, 4};
   localparam int CPT [2] = '{4, 6};
   localparam int GM  [2] = '{2, 3};

   logic clock;
   logic rst_n;
   logic sby, mstp, mstrtp, goj_req, strt_req;

   logic [11:0] tp0;
   logic [3:0]  idx0;
   logic [1:0]  ph0;
   logic        rt0, wt0, ct0, end0, stop0, stby0, gj0, gjn0;

   logic [3:0]  tp1;
   logic [1:0]  idx1;
   logic [2:0]  ph1;
   logic        rt1, wt1, ct1, end1, stop1, stby1, gj1, gjn1;

   int n_checks = 0;
   int n_errors = 0;

   // Model state per instance: position in MCT, mode (0 run, 1 stop, 2 standby),
   // previous mstrtp, pending restart, MCTs of gojam left, gojam level.
   int m_pos   [2];
   int m_mode  [2];
   int m_prev  [2];
   int m_pend  [2];
   int m_gleft [2];
   int m_gj    [2];

   mct_timer u_dut0 (
      .clock(clock), .rst_n(rst_n), .sby(sby), .mstp(mstp), .mstrtp(mstrtp),
      .goj_req(goj_req), .strt_req(strt_req),
      .tp(tp0), .tp_idx(idx0), .phase(ph0), .rt(rt0), .wt(wt0), .ct(ct0),
      .mct_end(end0), .stop(stop0), .stby(stby0), .gojam(gj0), .gojam_n(gjn0)
   );

   mct_timer #(.NUM_TP(4), .CLK_PER_TP(6), .GOJAM_MCT(3)) u_dut1 (
      .clock(clock), .rst_n(rst_n), .sby(sby), .mstp(mstp), .mstrtp(mstrtp),
      .goj_req(goj_req), .strt_req(strt_req),
      .tp(tp1), .tp_idx(idx1), .phase(ph1), .rt(rt1), .wt(wt1), .ct(ct1),
      .mct_end(end1), .stop(stop1), .stby(stby1), .gojam(gj1), .gojam_n(gjn1)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset(input int k);
      m_pos[k]   = 0;
      m_mode[k]  = 0;
      m_prev[k]  = 0;
      m_pend[k]  = 0;
      m_gleft[k] = GM[k];
      m_gj[k]    = 1;
   endtask

   // One clock edge of the behavioural model, using the inputs the DUT samples.
   task automatic model_step(input int k);
      int  mct;
      bit  mend, edge_s, req;
      if (!rst_n) begin
         model_reset(k);
         return;
      end
      mct    = NTP[k] * CPT[k];
      mend   = (m_mode[k] == 0) && (m_pos[k] == mct - 1);
      edge_s = mstrtp && (m_prev[k] == 0);
      req    = goj_req || strt_req;
      if (m_mode[k] == 2 && !sby) begin
         m_gleft[k] = GM[k];
         m_gj[k]    = 1;
         m_pend[k]  = m_pend[k] | int'(req);
      end else if (mend) begin
         if (m_pend[k] != 0) begin
            m_gleft[k] = GM[k];
            m_gj[k]    = 1;
         end else if (m_gleft[k] > 0) begin
            m_gleft[k]--;
            m_gj[k] = (m_gleft[k] > 0) ? 1 : 0;
         end
         m_pend[k] = int'(req);
      end else begin
         m_pend[k] = m_pend[k] | int'(req);
      end
      case (m_mode[k])
         0: begin
            if (mend) begin
               m_pos[k] = 0;
               if (sby) m_mode[k] = 2;
               else if (mstp) m_mode[k] = 1;
            end else begin
               m_pos[k]++;
            end
         end
         1: begin
            m_pos[k] = 0;
            if (!mstp || edge_s) m_mode[k] = 0;
         end
         default: begin
            m_pos[k] = 0;
            if (!sby) m_mode[k] = 0;
         end
      endcase
      m_prev[k] = int'(mstrtp);
   endtask

   task automatic compare_inst(input int k, input logic [31:0] a_tp, input logic [31:0] a_idx,
                               input logic [31:0] a_ph, input logic [31:0] a_str,
                               input logic [31:0] a_halt, input logic [31:0] a_gj);
      bit run;
      int idx, ph, mct;
      logic [31:0] e_tp, e_str, e_halt, e_gj;
      mct  = NTP[k] * CPT[k];
      run  = rst_n && (m_mode[k] == 0);
      idx  = m_pos[k] / CPT[k];
      ph   = m_pos[k] % CPT[k];
      e_tp = run ? (32'd1 << idx) : 32'd0;
      e_str  = {28'd0, run && ph == 0, run && ph == CPT[k] / 2,
                run && ph == CPT[k] - 1, run && m_pos[k] == mct - 1};
      e_halt = {30'd0, m_mode[k] == 1, m_mode[k] == 2};
      e_gj   = {30'd0, m_gj[k] != 0, m_gj[k] == 0};
      check($sformatf("tp[%0d]", k), a_tp, e_tp);
      check($sformatf("tp_idx[%0d]", k), a_idx, 32'(idx));
      check($sformatf("phase[%0d]", k), a_ph, 32'(ph));
      check($sformatf("rt_wt_ct_end[%0d]", k), a_str, e_str);
      check($sformatf("stop_stby[%0d]", k), a_halt, e_halt);
      check($sformatf("gojam[%0d]", k), a_gj, e_gj);
   endtask

   task automatic compare_all();
      compare_inst(0, 32'(tp0), 32'(idx0), 32'(ph0), {28'd0, rt0, wt0, ct0, end0},
                   {30'd0, stop0, stby0}, {30'd0, gj0, gjn0});
      compare_inst(1, 32'(tp1), 32'(idx1), 32'(ph1), {28'd0, rt1, wt1, ct1, end1},
                   {30'd0, stop1, stby1}, {30'd0, gj1, gjn1});
   endtask

   // Advance one clock: model follows the edge, outputs compared on the falling edge.
   task automatic cycle();
      @(posedge clock);
      model_step(0);
      model_step(1);
      @(negedge clock);
      compare_all();
   endtask

   task automatic wait_pos0(input int target, input string tag);
      int n;
      n = 0;
      while (m_pos[0] != target && n < 300) begin
         cycle();
         n++;
      end
      check({tag, "_idx"}, 32'(idx0), 32'(target / CPT[0]));
      check({tag, "_phase"}, 32'(ph0), 32'(target % CPT[0]));
   endtask

   task automatic wait_mode0(input int target, input string tag);
      int n;
      n = 0;
      while (m_mode[0] != target && n < 300) begin
         cycle();
         n++;
      end
      check(tag, {30'd0, stop0, stby0}, (target == 1) ? 32'd2 : 32'd1);
   endtask

   initial begin
      int g0, g1, e0, e1, act;
      rst_n = 1'b0; sby = 1'b0; mstp = 1'b0; mstrtp = 1'b0;
      goj_req = 1'b0; strt_req = 1'b0;
      model_reset(0);
      model_reset(1);
      repeat (3) cycle();

      // Release reset: T01 / phase 0 visible before the first edge.
      rst_n = 1'b1;
      #1;
      check("t01_first", 32'(tp0), 32'h001);
      check("phase_first", 32'(ph0), 32'd0);
      compare_all();
      g0 = int'(gj0); g1 = int'(gj1); e0 = int'(end0); e1 = int'(end1);
      repeat (200) begin
         cycle();
         g0 += int'(gj0); g1 += int'(gj1); e0 += int'(end0); e1 += int'(end1);
      end
      check("gojam_len0", 32'(g0), 32'd96);
      check("gojam_len1", 32'(g1), 32'd72);
      check("mct_ends0", 32'(e0), 32'd4);
      check("mct_ends1", 32'(e1), 32'd8);

      // One-clock restart pulse mid-MCT acts only at the boundary.
      wait_pos0(20, "goj_at_t06");
      goj_req = 1'b1;
      cycle();
      goj_req = 1'b0;
      check("goj_not_yet", 32'(gj0), 32'd0);
      g0 = 0;
      repeat (150) begin
         cycle();
         g0 += int'(gj0);
      end
      check("goj_len0", 32'(g0), 32'd96);

      // Monitor stop and single step.
      mstp = 1'b1;
      wait_mode0(1, "stop_set");
      check("stop_tp", 32'(tp0), 32'd0);
      repeat (5) cycle();
      mstrtp = 1'b1;
      act = 0;
      repeat (100) begin
         cycle();
         act += (tp0 != 12'd0) ? 1 : 0;
      end
      check("step_len", 32'(act), 32'd48);
      mstp = 1'b0;
      cycle();
      check("resume_t01", 32'(tp0), 32'h001);
      mstrtp = 1'b0;
      repeat (20) cycle();

      // Standby requested mid-MCT, then wake with restart.
      wait_pos0(12, "sby_at_t04");
      sby = 1'b1;
      wait_mode0(2, "stby_set");
      check("stby_tp", 32'(tp0), 32'd0);
      repeat (10) cycle();
      sby = 1'b0;
      cycle();
      check("wake_t01", 32'(tp0), 32'h001);
      g0 = int'(gj0);
      repeat (149) begin
         cycle();
         g0 += int'(gj0);
      end
      check("wake_gojam0", 32'(g0), 32'd96);

      // Asynchronous reset in the middle of T08 phase 2.
      wait_pos0(30, "rst_at_t08");
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_tp", 32'(tp0), 32'd0);
      check("arst_strobes", {28'd0, rt0, wt0, ct0, end0}, 32'd0);
      check("arst_gojam", {30'd0, gj0, gjn0}, 32'd2);
      model_reset(0);
      model_reset(1);
      repeat (2) cycle();
      rst_n = 1'b1;
      #1;
      check("rel_t01", 32'(tp0), 32'h001);
      repeat (100) cycle();

      // Randomised traffic on all control inputs, including short resets.
      repeat (4000) begin
         goj_req  = ($urandom_range(0, 199) == 0);
         strt_req = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 299) == 0) mstp = ~mstp;
         if ($urandom_range(0, 19) == 0) mstrtp = ~mstrtp;
         if ($urandom_range(0, 399) == 0) sby = ~sby;
         rst_n = ($urandom_range(0, 999) != 0);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mct_timer.md
Name: mct_timer

Overview:
- Parametrised successor to the fixed AGC timer.
- Generates the memory-cycle-time (MCT) sequence: phase counter, one-hot time pulses, and RT/WT/CT strobes.
- Adds monitor stop/single-step, standby hold and GOJAM restart sequencing, all aligned to MCT boundaries.
- Drives the sequence generator, memory timing and control-pulse decode.

Parameters:
- NUM_TP, 12: time pulses per MCT (>=2).
- CLK_PER_TP, 4: clocks per time pulse (>=4).
- GOJAM_MCT, 2: length of the GOJAM assertion in whole MCTs (>=1).
- Derived: TPW = clog2(NUM_TP); PW = clog2(CLK_PER_TP); CW = clog2(GOJAM_MCT+1).

Ports:
- clock  in  1  master clock
- rst_n  in  1  asynchronous active-low reset
- sby  in  1  standby request
- mstp  in  1  monitor stop enable
- mstrtp  in  1  monitor start; rising edge steps one MCT
- goj_req  in  1  restart request (level or pulse)
- strt_req  in  1  alarm restart request (level or pulse)
- tp  out  NUM_TP  one-hot time pulse; bit 0 = T01
- tp_idx  out  TPW  current time-pulse index
- phase  out  PW  clock index within the time pulse
- rt  out  1  read strobe
- wt  out  1  write strobe
- ct  out  1  clear strobe
- mct_end  out  1  last clock of the MCT
- stop  out  1  halted by monitor stop
- stby  out  1  halted by standby
- gojam  out  1  restart in progress
- gojam_n  out  1  ~gojam

Behaviour:
- **Reset** (async, rst_n=0):
  - tp_idx=0, phase=0, stop=0, stby=0, edge register=0, pending=0.
  - gojam counter=GOJAM_MCT, gojam=1, gojam_n=0.
  - tp, rt, wt, ct and mct_end are all 0 while rst_n=0.
  - The first clock after release shows T01, phase 0.
- **run** = !stop && !stby.
  - All strobes are combinational decodes of registered state, gated by run:
  - tp = run ? (1<<tp_idx) : 0.
  - rt = run && phase==0.
  - wt = run && phase==CLK_PER_TP/2.
  - ct = run && phase==CLK_PER_TP-1.
  - mct_end = run && tp_idx==NUM_TP-1 && phase==CLK_PER_TP-1.
- **Counting** (when run):
  - phase increments each clock; at CLK_PER_TP-1 it wraps to 0 and tp_idx increments.
  - At mct_end both wrap to 0.
  - MCT length = NUM_TP*CLK_PER_TP clocks.
  - When not run, counters hold at 0/0.
- **Priority** at an mct_end edge: standby > monitor stop > continue.
- **Standby**:
  - sby is sampled only on an mct_end clock; if 1, stby<=1.
  - While stby=1 and sby=0: stby<=0 next clock, and the gojam counter reloads to GOJAM_MCT with gojam<=1 (restart on wake).
- **Monitor stop**:
  - On an mct_end clock with mstp=1 and no step grant pending, stop<=1.
  - While stop=1, mstp=0 clears stop on the next clock.
  - While stop=1, a rising edge of mstrtp (registered compare) clears stop and sets a step grant.
  - The next mct_end consumes the grant, then stop re-evaluates against mstp.
  - Holding mstrtp high yields exactly one MCT.
- **GOJAM**:
  - goj_req|strt_req on any clock sets pending (including while halted).
  - At mct_end, if pending: counter<=GOJAM_MCT, gojam<=1, pending<=0.
  - Otherwise, at mct_end with counter>0: counter decrements; on reaching 0, gojam<=0.
  - gojam changes only on the clock ending an MCT, so it spans whole MCTs.
  - A request during gojam reloads the counter at the next mct_end.
  - Counter and gojam freeze while halted.
  - Simultaneous pending and expiry: reload wins, gojam stays 1.

Test Plan:
- **Defaults, release rst_n:** tp=12'h001 on cycle 1; mct_end every 48 clocks; rt/wt/ct at phase 0/2/3; gojam=1 for exactly 96 clocks, then 0.
- **goj_req 1-clock pulse at tp_idx=5:** gojam unchanged until mct_end; gojam=1 from the next clock for 96 clocks.
- **mstp=1:** stop=1 after mct_end, tp=0. One mstrtp rising edge gives exactly 48 active clocks, then stop=1. mstrtp held high gives no second MCT. mstp=0 resumes at T01.
- **sby=1 at tp_idx=3:** current MCT completes, then stby=1 and tp=0. sby=0 resumes T01 phase 0 with gojam=1 for 96 clocks.
- **rst_n low at tp_idx=7, phase=2:** tp/rt/wt/ct=0 immediately without a clock edge; gojam=1 immediately.
- **NUM_TP=4, CLK_PER_TP=6, GOJAM_MCT=3:** MCT=24 clocks; wt at phase 3; gojam lasts 72 clocks after reset.
